// File: rtl/stream_sweep_controller.sv
// rtl/stream_sweep_controller.sv - sequences one streaming pass of the LBM lattice through streaming_unit
//
// Walks every node (x,y) in raster order. For each of the 9 directions it
// reads the post-collision value from the source bank and writes it to the
// streamed destination reported by the combinational streaming_unit.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a pass (IDLE only) / cancel a running pass
//   busy, done          pass in progress / one-cycle completion pulse
//   x, y                current node coordinates to streaming_unit
//   write_addresses     9 streamed destinations, slice k = direction k, MSB = out of grid
//   rd_en/rd_addr/rd_dir/rd_data         source bank read, data one cycle after rd_en
//   wr_en/wr_addr/wr_dir/wr_data/wr_ready destination bank write handshake
//   node_count, skip_count               saturating per-pass statistics
module stream_sweep_controller #(
    parameter int GRID_DIM      = 256,
    parameter int SIDE_LENGTH   = 16,
    parameter int ADDRESS_WIDTH = $clog2(GRID_DIM) + 1,
    parameter int DATA_WIDTH    = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    output logic signed [ADDRESS_WIDTH-1:0] x,
    output logic signed [ADDRESS_WIDTH-1:0] y,
    input  logic [9*ADDRESS_WIDTH-1:0]      write_addresses,
    output logic                            rd_en,
    output logic [ADDRESS_WIDTH-2:0]        rd_addr,
    output logic [3:0]                      rd_dir,
    input  logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            wr_en,
    output logic [ADDRESS_WIDTH-2:0]        wr_addr,
    output logic [3:0]                      wr_dir,
    output logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            wr_ready,
    output logic [CNT_WIDTH-1:0]            node_count,
    output logic [CNT_WIDTH-1:0]            skip_count
);

    localparam int IDX_W = ADDRESS_WIDTH - 1;
    localparam logic [ADDRESS_WIDTH-1:0] COORD_LAST = ADDRESS_WIDTH'(SIDE_LENGTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] COORD_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] SIDE       = ADDRESS_WIDTH'(SIDE_LENGTH);
    localparam logic [3:0]               K_LAST     = 4'd8;
    localparam logic [CNT_WIDTH-1:0]     CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;
    logic [3:0]               k;
    logic [ADDRESS_WIDTH-1:0] slice;
    logic                     oob;
    logic                     last_k;
    logic                     last_node;
    logic                     step;
    state_t                   adv_state;

    // Destination for the current direction; k never exceeds 8.
    always_comb begin
        slice = '0;
        for (int i = 0; i < 9; i++) begin
            if (k == 4'(i)) begin
                slice = write_addresses[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    assign oob       = slice[ADDRESS_WIDTH-1];
    assign last_k    = (k == K_LAST);
    assign last_node = last_k && (x == COORD_LAST) && (y == COORD_LAST);

    // One direction finished this cycle (skipped, or its write handshaked).
    // abort suppresses it so an aborted write is never counted.
    assign step      = !abort && (((state == READ) && oob) || ((state == WRITE) && wr_ready));
    assign adv_state = last_node ? DONE : READ;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = READ;
            READ:    if (abort) state_next = IDLE;
                     else if (oob) state_next = adv_state;
                     else state_next = CAPT;
            CAPT:    if (abort) state_next = IDLE;
                     else state_next = WRITE;
            WRITE:   if (abort) state_next = IDLE;
                     else if (wr_ready) state_next = adv_state;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic; strobes drop combinationally on abort
    always_comb begin
        busy    = (state == READ) || (state == CAPT) || (state == WRITE);
        done    = (state == DONE);
        rd_en   = (state == READ) && !oob && !abort;
        wr_en   = (state == WRITE) && !abort;
        rd_addr = IDX_W'(y * SIDE + x);
        rd_dir  = k;
    end

    // Datapath: node walk, write staging and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= '0;
            y          <= '0;
            k          <= '0;
            wr_addr    <= '0;
            wr_dir     <= '0;
            wr_data    <= '0;
            node_count <= '0;
            skip_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x          <= '0;
                        y          <= '0;
                        k          <= '0;
                        node_count <= '0;
                        skip_count <= '0;
                    end
                end
                CAPT: begin
                    if (!abort) begin
                        wr_data <= rd_data;
                        wr_addr <= slice[IDX_W-1:0];
                        wr_dir  <= k;
                    end
                end
                DONE: begin
                    x <= '0;
                    y <= '0;
                    k <= '0;
                end
                default: ;
            endcase

            if (step && (state == READ) && (skip_count != '1)) begin
                skip_count <= skip_count + CNT_ONE;
            end

            if (step) begin
                if (!last_k) begin
                    k <= k + 4'd1;
                end else begin
                    k <= '0;
                    if (node_count != '1) begin
                        node_count <= node_count + CNT_ONE;
                    end
                    // The final node leaves x/y in place; DONE clears them.
                    if (!last_node) begin
                        if (x == COORD_LAST) begin
                            x <= '0;
                            y <= y + COORD_ONE;
                        end else begin
                            x <= x + COORD_ONE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/stream_sweep_controller.md
Name: stream_sweep_controller

Overview:
- Sequences one full streaming pass of the LBM lattice through the combinational streaming_unit.
- Walks every node (x,y) in raster order and drives x/y into streaming_unit. Reads the 9 post-collision distributions of that node from the source bank, one at a time, and writes each to its streamed destination address in the destination bank.
- Sits between the top-level step sequencer (start/done) and the two distribution memories.

Parameters:
- GRID_DIM, 256, total lattice nodes.
- SIDE_LENGTH, 16, nodes per row/column.
- ADDRESS_WIDTH, $clog2(GRID_DIM)+1, streaming_unit coordinate/address width; MSB is the out-of-grid flag.
- DATA_WIDTH, 16, width of one distribution value.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running pass.
- busy  out  1  high from the cycle after accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal pass completion.
- x  out  ADDRESS_WIDTH  signed node column to streaming_unit.
- y  out  ADDRESS_WIDTH  signed node row to streaming_unit.
- write_addresses  in  9*ADDRESS_WIDTH  streamed destinations from streaming_unit; direction k occupies bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- rd_en  out  1  source-bank read strobe.
- rd_addr  out  ADDRESS_WIDTH-1  source node index, y*SIDE_LENGTH+x.
- rd_dir  out  4  direction index k (0..8).
- rd_data  in  DATA_WIDTH  source data, valid exactly 1 cycle after rd_en.
- wr_en  out  1  destination write request.
- wr_addr  out  ADDRESS_WIDTH-1  destination node index, low bits of slice k.
- wr_dir  out  4  direction index k.
- wr_data  out  DATA_WIDTH  value to write.
- wr_ready  in  1  destination accepts; transfer occurs when wr_en and wr_ready are both high.
- node_count  out  CNT_WIDTH  nodes completed in the current/last pass.
- skip_count  out  CNT_WIDTH  out-of-grid directions skipped in the current/last pass.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; x, y, k = 0; rd_en, wr_en, busy, done = 0; rd_addr, rd_dir, wr_addr, wr_dir, wr_data = 0; node_count, skip_count = 0.
- FSM states: IDLE, READ, CAPT, WRITE, DONE.
- IDLE:
  - start high: clear x, y, k and both counters, then go to READ.
  - start while not in IDLE is ignored.
- READ: evaluate slice k of write_addresses. This is valid because x/y have been stable at least one cycle, and streaming_unit is combinational.
  - Slice MSB = 1 (out of grid): no memory access; skip_count += 1; ADVANCE.
  - Otherwise: rd_en = 1 for this cycle, rd_addr = y*SIDE_LENGTH+x, rd_dir = k; go to CAPT.
- CAPT:
  - Register rd_data into wr_data, slice k low ADDRESS_WIDTH-1 bits into wr_addr, and k into wr_dir.
  - Go to WRITE.
- WRITE:
  - wr_en = 1, with wr_addr/wr_dir/wr_data held stable until wr_ready.
  - On the handshake cycle: ADVANCE; wr_en is low in the next cycle unless the next state is WRITE again (impossible by construction).
- ADVANCE, evaluated in the same cycle as the transition:
  - k < 8: k += 1, go to READ.
  - k = 8: k = 0, node_count += 1, then:
    - If x = SIDE_LENGTH-1 and y = SIDE_LENGTH-1: go to DONE.
    - Else if x = SIDE_LENGTH-1: x = 0, y += 1, go to READ.
    - Else: x += 1, go to READ.
- DONE: done = 1 for exactly one cycle, busy = 0, go to IDLE. x/y return to 0.
- Latency:
  - Valid direction with wr_ready tied high: 3 cycles (READ, CAPT, WRITE).
  - Skipped direction: 1 cycle.
  - Interior node: 27 cycles.
  - Full pass of 256 nodes with no skips: 6912 cycles + 1 DONE cycle.
- abort:
  - In any non-IDLE state, next state is IDLE; wr_en/rd_en drop immediately; no done pulse.
  - Counters hold their values until the next start.
  - abort has priority over wr_ready in the same cycle (that write is not counted as performed).
- Simultaneous start and abort in IDLE: start wins.
- Counters saturate at all-ones.
- busy is high in READ, CAPT and WRITE.

Test Plan:
- Reset mid-WRITE (wr_ready held low, assert rst_n low) -> all outputs 0 asynchronously, state IDLE; the next start begins at x = y = 0.
- Single pass, streaming_unit model with periodic wrap, wr_ready = 1 -> 2304 writes, each value lands at the expected periodic destination; done pulses at cycle 6913 after start; node_count = 256; skip_count = 0.
- Node (0,0) with directions 3, 6, 7 flagged out-of-grid (MSB set) -> 3 skip cycles, 6 writes; node takes 21 cycles; skip_count increments by 3.
- wr_ready low for 5 cycles at node (3,2), k = 4 -> wr_en, wr_addr, wr_data held constant for 6 cycles; exactly one transfer; no extra rd_en.
- abort during node (7,7) -> IDLE next cycle, no done; node_count = 119 held; restart completes normally.
- start pulsed while busy -> ignored; pass length and counts unchanged.
